// File: rtl/noc_vc_credit_tx.sv
// Multi-VC credit-based NoC link transmitter: one FIFO and one credit counter per VC,
// with a round-robin arbiter driving the shared enable/data/vc link from registers.

module noc_vc_credit_lane #(
    parameter int DATA_W  = 16,
    parameter int CREDITS = 4,
    parameter int QDEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    input  logic              credit,
    output logic              ready,
    output logic              nonempty,
    output logic              has_cred,
    output logic [DATA_W-1:0] head,
    output logic              cerr
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(QDEPTH);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    logic [DATA_W-1:0] mem [QDEPTH];
    logic [AW-1:0]     wp, rp;
    logic [AW:0]       cnt;
    logic [CW-1:0]     cred;

    assign ready    = (cnt != FULL);
    assign nonempty = (cnt != '0);
    assign has_cred = (cred != '0);
    assign head     = mem[rp];
    // A returned credit only overflows when no grant consumes one on the same edge.
    assign cerr     = credit & ~pop & (cred == CMAX);

    always_ff @(posedge clk)
        if (push) mem[wp] <= wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            cred <= CMAX;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            case ({pop, credit})
                2'b10:   cred <= cred - 1'b1;
                2'b01:   if (cred != CMAX) cred <= cred + 1'b1;
                default: cred <= cred;
            endcase
        end
    end
endmodule

module noc_vc_credit_tx #(
    parameter int DATA_W  = 16,
    parameter int NUM_VC  = 2,
    parameter int CREDITS = 4,
    parameter int QDEPTH  = 4,
    parameter int VC_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_VC-1:0]        in_valid,
    input  logic [NUM_VC*DATA_W-1:0] in_data,
    output logic [NUM_VC-1:0]        in_ready,
    output logic                     enable,
    output logic [DATA_W-1:0]        data,
    output logic [VC_W-1:0]          vc,
    input  logic [NUM_VC-1:0]        credit,
    output logic                     credit_err
);
    logic [NUM_VC-1:0]             push, ready, nonempty, has_cred, elig, gnt, cerr;
    logic [NUM_VC-1:0][DATA_W-1:0] heads;
    logic [2*NUM_VC-1:0]           dbl;
    logic [NUM_VC-1:0]             rot;
    logic [VC_W-1:0]               last_grant, gvc;
    logic [DATA_W-1:0]             gdata;
    logic                          any;

    assign in_ready = ready;
    assign push     = in_valid & ready;
    assign elig     = nonempty & has_cred;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_lane
        noc_vc_credit_lane #(.DATA_W(DATA_W), .CREDITS(CREDITS), .QDEPTH(QDEPTH)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .push    (push[v]),
            .wdata   (in_data[v*DATA_W +: DATA_W]),
            .pop     (gnt[v]),
            .credit  (credit[v]),
            .ready   (ready[v]),
            .nonempty(nonempty[v]),
            .has_cred(has_cred[v]),
            .head    (heads[v]),
            .cerr    (cerr[v])
        );
    end

    // Rotate eligibility so bit 0 is the VC after last_grant; first set bit wins.
    always_comb begin
        int sel;
        sel   = 0;
        any   = 1'b0;
        gvc   = '0;
        gnt   = '0;
        gdata = '0;
        dbl   = {elig, elig} >> (int'(last_grant) + 1);
        rot   = dbl[NUM_VC-1:0];
        for (int i = 0; i < NUM_VC; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                sel = int'(last_grant) + 1 + i;
                if (sel >= NUM_VC) sel = sel - NUM_VC;
            end
        end
        for (int v = 0; v < NUM_VC; v++) begin
            if (any && sel == v) begin
                gnt[v] = 1'b1;
                gdata  = heads[v];
            end
        end
        gvc = VC_W'(sel);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable     <= 1'b0;
            data       <= '0;
            vc         <= '0;
            last_grant <= VC_W'(NUM_VC - 1);
            credit_err <= 1'b0;
        end else begin
            enable <= any;
            if (any) begin
                data       <= gdata;
                vc         <= gvc;
                last_grant <= gvc;
            end
            if (|cerr) credit_err <= 1'b1;
        end
    end
endmodule
